// File: rtl/signed_divider_if.sv
// Start/busy/done handshake and result bus for the sequential signed divider.
// The requester uses the master modport; the divider itself uses slave.
interface signed_divider_if #(
    parameter int N = 4
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   q;
    logic [N-1:0]     r;
    logic             dz;
    logic             ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, q, r, dz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, q, r, dz, ovf
    );
endinterface

// File: rtl/signed_divider.sv
// Sequential 2N/N signed divider: restoring division on magnitudes, one quotient bit per
// clock, then sign fix-up. Optional macro SIGNED_DIV_ZERO_FAST_EN short-cuts divide by zero.
module signed_divider #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    signed_divider_if.slave   bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST    = CW'(W - 1);
    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   qm_q, qm_d;      // raw dividend, then its magnitude, then quotient magnitude
    logic [N-1:0]   dm_q, dm_d;      // raw divisor, then its magnitude
    logic [N:0]     pr_q, pr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           qneg_q, qneg_d;
    logic           rneg_q, rneg_d;
    logic [W-1:0]   q_q, q_d;
    logic [N-1:0]   r_q, r_d;
    logic           dz_q, dz_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    logic [N+1:0]   shifted;
    logic [N+1:0]   trial;
    logic           div_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            qm_q    <= '0;
            dm_q    <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qm_q    <= qm_d;
            dm_q    <= dm_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        qm_d     = qm_q;
        dm_d     = dm_q;
        pr_d     = pr_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        q_d      = q_q;
        r_d      = r_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        // Partial remainder stays below 2^N, so the top bit of shifted is always 0 and
        // trial[N+1] is the borrow of the trial subtraction.
        shifted  = {pr_q, qm_q[W-1]};
        trial    = shifted - {2'b00, dm_q};
        div_zero = (dm_q == '0);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    qm_d    = bus.dividend;
                    dm_d    = bus.divisor;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                qneg_d  = qm_q[W-1] ^ dm_q[N-1];
                rneg_d  = qm_q[W-1];
                qm_d    = qm_q[W-1] ? (W'(0) - qm_q) : qm_q;
                dm_d    = dm_q[N-1] ? (N'(0) - dm_q) : dm_q;
                pr_d    = '0;
                cnt_d   = '0;
                state_d = ITER;
`ifdef SIGNED_DIV_ZERO_FAST_EN
                if (div_zero) begin
                    state_d = FIX;
                end
`endif
            end
            ITER: begin
                if (trial[N+1]) begin
                    pr_d = shifted[N:0];
                end else begin
                    pr_d = trial[N:0];
                end
                qm_d  = {qm_q[W-2:0], ~trial[N+1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (div_zero) begin
                    q_d   = '1;
                    r_d   = '0;
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    q_d   = qneg_q ? (W'(0) - qm_q) : qm_q;
                    r_d   = rneg_q ? (N'(0) - pr_q[N-1:0]) : pr_q[N-1:0];
                    dz_d  = 1'b0;
                    ovf_d = (qm_q == MIN_NEG) && !qneg_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.dz   = dz_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: the driver pushes integer-arithmetic expectations,
// an independent monitor pops and compares on every done pulse.
module tb_signed_divider;
    localparam int N = 4;
    localparam int W = 2 * N;
`ifdef SIGNED_DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    signed_divider_if #(.N(N)) bus ();

    signed_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ovf;
        int           lat;
        int           acc;
        int           a;
        int           b;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Truncating integer division: quotient toward zero, remainder follows the dividend.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int qi, ri;
        e.a = a;
        e.b = b;
        e.acc = 0;
        if (b == 0) begin
            e.q   = '1;
            e.r   = '0;
            e.dz  = 1'b1;
            e.ovf = 1'b0;
            e.lat = FAST ? 2 : W + 2;
        end else begin
            qi    = a / b;
            ri    = a % b;
            e.q   = qi[W-1:0];
            e.r   = ri[N-1:0];
            e.dz  = 1'b0;
            e.ovf = (qi == (1 << (W - 1)));
            e.lat = W + 2;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("txn %0d / %0d -> q=%h r=%h dz=%b ovf=%b lat=%0d",
                         mon_e.a, mon_e.b, bus.q, bus.r, bus.dz, bus.ovf, cyc - mon_e.acc);
                chk("q",       32'(bus.q),   32'(mon_e.q));
                chk("r",       32'(bus.r),   32'(mon_e.r));
                chk("dz",      32'(bus.dz),  32'(mon_e.dz));
                chk("ovf",     32'(bus.ovf), 32'(mon_e.ovf));
                chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                chk("busy_low_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    // Called at a negedge; waits for IDLE (or the done cycle), drives start for one edge.
    task automatic issue(input int a, input int b);
        int n = 0;
        exp_t e;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            chk("issue_timeout", 32'd1, 32'd0);
            return;
        end
        bus.start    = 1'b1;
        bus.dividend = a[W-1:0];
        bus.divisor  = b[N-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        e = model(a, b);
        e.acc = cyc;
        sb.push_back(e);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_q"},    32'(bus.q),    32'd0);
        chk({tag, "_r"},    32'(bus.r),    32'd0);
        chk({tag, "_dz"},   32'(bus.dz),   32'd0);
        chk({tag, "_ovf"},  32'(bus.ovf),  32'd0);
    endtask

    int dir_a[8] = '{100, -100, 100, -100, -128, -128, 7, 5};
    int dir_b[8] = '{7, 7, -7, -7, -1, 1, -8, 0};

    initial begin
        logic signed [W-1:0] ra;
        logic signed [N-1:0] rb;
        int n;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) issue(dir_a[i], dir_b[i]);

        // start re-asserted mid-operation must be ignored
        wait_idle();
        issue(100, 7);
        repeat (2) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd5;
        bus.divisor  = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;

        // start during the done cycle is accepted
        wait_idle();
        chk("done_cycle_before_restart", 32'(bus.done), 32'd1);
        issue(-100, -7);

        // asynchronous reset in the middle of ITER aborts the operation
        wait_idle();
        issue(100, 7);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(-128, -1);

        for (int i = 0; i < 150; i++) begin
            ra = W'($urandom);
            rb = N'($urandom_range(0, 15));
            issue(int'(ra), int'(rb));
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
